// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: arbitrates per-channel cache misses and fills one aligned block per miss from a pipelined memory.
// Latency: mem_req rises the cycle after a miss is sampled; array writes are combinational with mem_data_valid; tag write one cycle after the last return.
// Backpressure: mem_ready low holds mem_addr and the issue count; losing or waiting channels are held via fsm_busy.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   miss_detected, miss_address    per-channel level miss and packed byte addresses (channel i at [i*ADDR_W +: ADDR_W])
//   mem_req/mem_ready/mem_addr     word-request handshake towards memory
//   mem_data/mem_data_valid        in-order read returns
//   fsm_busy, fill_channel         per-channel stall, one-hot channel being filled
//   write_data_array, fill_index, fill_data, write_tag_array, fill_base   data/tag array write port
//   critical_valid, critical_data  early delivery of the requested word
module cache_fill_ctrl #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int WORDS          = 8,
  parameter int BYTES_PER_WORD = 2,
  parameter int NUM_CH         = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          miss_detected,
  input  logic [NUM_CH*ADDR_W-1:0]   miss_address,
  output logic                       mem_req,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_data,
  input  logic                       mem_data_valid,
  output logic [NUM_CH-1:0]          fsm_busy,
  output logic [NUM_CH-1:0]          fill_channel,
  output logic                       write_data_array,
  output logic [$clog2(WORDS)-1:0]   fill_index,
  output logic [DATA_W-1:0]          fill_data,
  output logic                       write_tag_array,
  output logic [ADDR_W-1:0]          fill_base,
  output logic                       critical_valid,
  output logic [DATA_W-1:0]          critical_data
);

  localparam int WI    = $clog2(WORDS);
  localparam int BO    = $clog2(BYTES_PER_WORD);
  localparam int OFF   = WI + BO;
  localparam int CNT_W = WI + 1;
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK = {ADDR_W{1'b1}} << OFF;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, TAG} state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [WI-1:0]       crit_idx_q, crit_idx_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]    rsp_cnt_q, rsp_cnt_d;
  logic [DATA_W-1:0]   crit_data_q, crit_data_d;
  logic                crit_vld_q, crit_vld_d;

  logic [NUM_CH-1:0]   sel_oh;
  logic [ADDR_W-1:0]   sel_addr;
  logic                ret;

  // Lowest asserted miss wins: isolate the least-significant set bit.
  always_comb begin
    sel_oh   = miss_detected & (~miss_detected + NUM_CH'(1));
    sel_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_oh[i]) sel_addr = miss_address[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    state_d          = state_q;
    ch_d             = ch_q;
    base_d           = base_q;
    crit_idx_d       = crit_idx_q;
    issue_cnt_d      = issue_cnt_q;
    rsp_cnt_d        = rsp_cnt_q;
    crit_data_d      = crit_data_q;
    crit_vld_d       = 1'b0;
    mem_req          = 1'b0;
    mem_addr         = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    ret              = 1'b0;

    case (state_q)
      IDLE: begin
        if (|miss_detected) begin
          ch_d        = sel_oh;
          base_d      = sel_addr & BLK_MASK;
          crit_idx_d  = WI'(sel_addr >> BO);
          issue_cnt_d = '0;
          rsp_cnt_d   = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = base_q + (ADDR_W'(issue_cnt_q) << BO);
        ret      = mem_data_valid;
        if (mem_ready) begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          if (issue_cnt_q == LAST) state_d = DRAIN;
        end
      end
      DRAIN: ret = mem_data_valid;
      TAG: begin
        write_tag_array = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Returns are handled after the state case so that the last return
    // takes precedence over the REQ->DRAIN move (zero-latency memory).
    if (ret) begin
      write_data_array = 1'b1;
      rsp_cnt_d        = rsp_cnt_q + CNT_W'(1);
      if (rsp_cnt_q[WI-1:0] == crit_idx_q) begin
        crit_data_d = mem_data;
        crit_vld_d  = 1'b1;
      end
      if (rsp_cnt_q == LAST) state_d = TAG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      base_q      <= '0;
      crit_idx_q  <= '0;
      issue_cnt_q <= '0;
      rsp_cnt_q   <= '0;
      crit_data_q <= '0;
      crit_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      base_q      <= base_d;
      crit_idx_q  <= crit_idx_d;
      issue_cnt_q <= issue_cnt_d;
      rsp_cnt_q   <= rsp_cnt_d;
      crit_data_q <= crit_data_d;
      crit_vld_q  <= crit_vld_d;
    end
  end

  assign fill_channel   = (state_q != IDLE) ? ch_q : '0;
  assign fsm_busy       = miss_detected | fill_channel;
  assign fill_index     = rsp_cnt_q[WI-1:0];
  assign fill_data      = mem_data;
  assign fill_base      = base_q;
  assign critical_valid = crit_vld_q;
  assign critical_data  = crit_data_q;

endmodule
